// File: rtl/onehot_4_pkg.sv
// Shared note-pipeline types and widths for the one-hot lane decoder.
// Also used by the song engine for note identifiers and lane vectors.
package onehot_4_pkg;

    localparam int NOTE_W    = 4;
    localparam int ONEHOT_W  = 16;
    localparam int REST_CODE = 15;

    typedef logic [NOTE_W-1:0]   note_id_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

endpackage

// File: rtl/onehot_4_if.sv
// Note-in / lane-vector-out bundle for onehot_4.
// The master side drives notes; the slave side (the decoder) returns lanes.
interface onehot_4_if
    import onehot_4_pkg::*;
#(
    parameter int IN_W  = NOTE_W,
    parameter int OUT_W = ONEHOT_W
);

    logic             in_valid;
    logic [IN_W-1:0]  to_encode;
    logic [OUT_W-1:0] encoded;
    logic             out_valid;
    logic             is_rest;

    modport master (
        output in_valid,
        output to_encode,
        input  encoded,
        input  out_valid,
        input  is_rest
    );

    modport slave (
        input  in_valid,
        input  to_encode,
        output encoded,
        output out_valid,
        output is_rest
    );

endinterface

// File: rtl/onehot_4_core.sv
// Pure combinational note decode: code in, one-hot vector and rest flag out.
// With ONEHOT4_REST_MASK_EN defined, the rest code yields an all-dark vector.
module onehot_4_core
    import onehot_4_pkg::*;
#(
    parameter int IN_W      = NOTE_W,
    parameter int OUT_W     = ONEHOT_W,
    parameter int REST_CODE = onehot_4_pkg::REST_CODE
) (
    input  logic [IN_W-1:0]  code,
    output logic [OUT_W-1:0] decoded,
    output logic             rest
);

    logic [OUT_W-1:0] raw;

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_lane
            assign raw[gi] = (code == IN_W'(gi));
        end
    endgenerate

    assign rest = (code == IN_W'(REST_CODE));

`ifdef ONEHOT4_REST_MASK_EN
    assign decoded = rest ? '0 : raw;
`else
    assign decoded = raw;
`endif

endmodule

// File: rtl/onehot_4.sv
// Registered 4-to-16 one-hot note decoder with valid and rest tracking.
// Optional build macro: ONEHOT4_REST_MASK_EN (rest code loads an all-zero vector).
module onehot_4
    import onehot_4_pkg::*;
#(
    parameter int IN_W      = NOTE_W,
    parameter int OUT_W     = ONEHOT_W,
    parameter int REST_CODE = onehot_4_pkg::REST_CODE
) (
    input  logic        game_clock,
    input  logic        reset,
    onehot_4_if.slave   bus
);

    generate
        if (OUT_W != 2 ** IN_W) begin : g_bad_width
            $error("onehot_4: OUT_W must equal 2**IN_W");
        end
        if (REST_CODE < 0 || REST_CODE > OUT_W - 1) begin : g_bad_rest
            $error("onehot_4: REST_CODE out of range");
        end
    endgenerate

    logic [OUT_W-1:0] decoded;
    logic             rest_hit;

    logic [OUT_W-1:0] encoded_reg;
    logic             is_rest_reg;
    logic             out_valid_reg;

    onehot_4_core #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .REST_CODE (REST_CODE)
    ) u_core (
        .code    (bus.to_encode),
        .decoded (decoded),
        .rest    (rest_hit)
    );

    // Payload registers load only on accepted inputs, so an undriven code
    // while in_valid is low never reaches state.
    always_ff @(posedge game_clock or posedge reset) begin
        if (reset) begin
            encoded_reg   <= '0;
            is_rest_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                encoded_reg <= decoded;
                is_rest_reg <= rest_hit;
            end
        end
    end

    assign bus.encoded   = encoded_reg;
    assign bus.is_rest   = is_rest_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_onehot_4.sv
// Directed and random bench for onehot_4; expectations go through a queue
// at drive time and are popped after the following rising edge.
module tb_onehot_4;
    import onehot_4_pkg::*;

    typedef struct packed {
        logic [15:0] enc;
        logic        rest;
        logic        vld;
    } exp_t;

    logic game_clock;
    logic reset;

    onehot_4_if #(.IN_W(4), .OUT_W(16)) bus ();

    onehot_4 #(.IN_W(4), .OUT_W(16), .REST_CODE(15)) dut (
        .game_clock (game_clock),
        .reset      (reset),
        .bus        (bus)
    );

    initial game_clock = 1'b0;
    always #5 game_clock = ~game_clock;

    exp_t        sb_q[$];
    logic [15:0] model_enc;
    logic        model_rest;
    int          pass_count;
    int          total_count;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] expect_vec(input logic [3:0] code);
        logic [15:0] v;
        v = 16'h0000;
        v[code] = 1'b1;
`ifdef ONEHOT4_REST_MASK_EN
        if (code == 4'd15) v = 16'h0000;
`endif
        return v;
    endfunction

    // Called at a falling edge: drive, push expectation, check after next rise.
    task automatic drive(input logic v, input logic [3:0] code, input string tag);
        exp_t e;
        bus.in_valid  = v;
        bus.to_encode = code;
        if (v) begin
            model_enc  = expect_vec(code);
            model_rest = (code == 4'd15);
        end
        e.enc  = model_enc;
        e.rest = model_rest;
        e.vld  = v;
        sb_q.push_back(e);
        @(posedge game_clock);
        #1;
        e = sb_q.pop_front();
        check({tag, ".enc"},  bus.encoded, e.enc);
        check({tag, ".rest"}, {15'd0, bus.is_rest}, {15'd0, e.rest});
        check({tag, ".vld"},  {15'd0, bus.out_valid}, {15'd0, e.vld});
        if (bus.out_valid === 1'b1 && !(e.rest && e.enc == 16'h0000))
            check({tag, ".ones"}, 16'($countones(bus.encoded)), 16'd1);
        @(negedge game_clock);
    endtask

    initial begin
        logic [3:0] rc;
        pass_count  = 0;
        total_count = 0;
        model_enc   = 16'h0000;
        model_rest  = 1'b0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.to_encode = 4'hx;

        repeat (2) @(posedge game_clock);
        #1;
        check("rst.enc",  bus.encoded, 16'h0000);
        check("rst.rest", {15'd0, bus.is_rest}, 16'd0);
        check("rst.vld",  {15'd0, bus.out_valid}, 16'd0);
        @(negedge game_clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), $sformatf("sweep%0d", i));

        drive(1'b1, 4'd7, "hold.load");
        drive(1'b0, 4'd2,  "hold0");
        drive(1'b0, 4'hx,  "hold1");
        drive(1'b0, 4'd13, "hold2");

        drive(1'b1, 4'd15, "rest");
        drive(1'b1, 4'd3,  "after_rest");

        // Asynchronous reset between clock edges while 0x0080 is showing.
        drive(1'b1, 4'd7, "pre_rst");
        check("pre_rst.enc", bus.encoded, 16'h0080);
        #2;
        reset = 1'b1;
        #1;
        check("arst.enc",  bus.encoded, 16'h0000);
        check("arst.rest", {15'd0, bus.is_rest}, 16'd0);
        check("arst.vld",  {15'd0, bus.out_valid}, 16'd0);
        sb_q.delete();
        model_enc  = 16'h0000;
        model_rest = 1'b0;
        @(negedge game_clock);
        bus.in_valid = 1'b1;
        bus.to_encode = 4'd5;
        @(posedge game_clock);
        #1;
        check("arst_hold.enc", bus.encoded, 16'h0000);
        @(negedge game_clock);
        reset = 1'b0;

        drive(1'b0, 4'd9, "post_rst_idle");

        for (int i = 0; i < 1000; i++) begin
            rc = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 4) != 0), rc, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
